// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer that shares one external combinational ALU between two
// requesters: accept, drive the ALU from registers for one cycle, then return the result.
module alu_share_arbiter #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [N-1:0]     req_a0,
    input  logic [N-1:0]     req_b0,
    input  logic [1:0]       req_op0,
    input  logic [N-1:0]     req_a1,
    input  logic [N-1:0]     req_b1,
    input  logic [1:0]       req_op1,

    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [N-1:0]     rsp_result,
    output logic             rsp_zero,
    output logic             rsp_carry,
    output logic             rsp_sign,
    output logic             rsp_overflow,

    output logic [N-1:0]     alu_src_a,
    output logic [N-1:0]     alu_src_b,
    output logic [1:0]       alu_ctrl,
    input  logic [N-1:0]     alu_out,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_sign,
    input  logic             alu_overflow,

    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic               owner_q, owner_d;
    logic [N-1:0]       src_a_q, src_a_d;
    logic [N-1:0]       src_b_q, src_b_d;
    logic [1:0]         ctrl_q, ctrl_d;
    logic [N-1:0]       result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic [CNT_W-1:0]   ops_done_q, ops_done_d;

    logic               any_valid;
    logic               winner;

    // Single requester wins outright; on contention the one not granted last time wins.
    always_comb begin
        any_valid = |req_valid;
        winner    = 1'b0;
        if (&req_valid) begin
            winner = ~last_grant_q;
        end else if (req_valid[1]) begin
            winner = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        src_a_d      = src_a_q;
        src_b_d      = src_b_q;
        ctrl_d       = ctrl_q;
        result_d     = result_q;
        flags_d      = flags_q;
        ops_done_d   = ops_done_q;
        req_ready    = '0;
        rsp_valid    = '0;

        case (state_q)
            IDLE: begin
                // Gated by reset so the handshake output reads zero while reset is held.
                if (any_valid && !reset) begin
                    req_ready[winner] = 1'b1;
                    owner_d           = winner;
                    last_grant_d      = winner;
                    src_a_d           = winner ? req_a1  : req_a0;
                    src_b_d           = winner ? req_b1  : req_b0;
                    ctrl_d            = winner ? req_op1 : req_op0;
                    state_d           = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_out;
                flags_d  = {alu_zero, alu_carry, alu_sign, alu_overflow};
                state_d  = RESP;
            end
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) begin
                    ops_done_d = ops_done_q + CNT_W'(1);
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            src_a_q      <= '0;
            src_b_q      <= '0;
            ctrl_q       <= '0;
            result_q     <= '0;
            flags_q      <= '0;
            ops_done_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            src_a_q      <= src_a_d;
            src_b_q      <= src_b_d;
            ctrl_q       <= ctrl_d;
            result_q     <= result_d;
            flags_q      <= flags_d;
            ops_done_q   <= ops_done_d;
        end
    end

    // Operand registers double as the ALU drive, so they simply hold outside EXEC.
    assign alu_src_a    = src_a_q;
    assign alu_src_b    = src_b_q;
    assign alu_ctrl     = ctrl_q;
    assign rsp_result   = result_q;
    assign rsp_zero     = flags_q[3];
    assign rsp_carry    = flags_q[2];
    assign rsp_sign     = flags_q[1];
    assign rsp_overflow = flags_q[0];
    assign busy         = (state_q != IDLE);
    assign ops_done     = ops_done_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vector table, hand-written corner sequences,
// then random traffic against a transaction-level reference model.
module tb_alu_share_arbiter;

    localparam int N  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N-1:0]  req_a0, req_b0, req_a1, req_b1;
    logic [1:0]    req_op0, req_op1;
    logic [N-1:0]  rsp_result;
    logic          rsp_zero, rsp_carry, rsp_sign, rsp_overflow;
    logic [N-1:0]  alu_src_a, alu_src_b, alu_out;
    logic [1:0]    alu_ctrl;
    logic          alu_zero, alu_carry, alu_sign, alu_overflow;
    logic          busy;
    logic [CW-1:0] ops_done;

    always #5 clk = ~clk;

    alu_share_arbiter #(.N(N), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_op0(req_op0),
        .req_a1(req_a1), .req_b1(req_b1), .req_op1(req_op1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
        .rsp_sign(rsp_sign), .rsp_overflow(rsp_overflow),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .alu_out(alu_out), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .alu_sign(alu_sign), .alu_overflow(alu_overflow),
        .busy(busy), .ops_done(ops_done)
    );

    // ALU stub
    always_comb begin
        alu_out      = alu_src_a ^ alu_src_b;
        alu_zero     = ((alu_src_a ^ alu_src_b) == '0);
        alu_carry    = alu_src_a[7];
        alu_sign     = alu_out[7];
        alu_overflow = alu_src_b[0];
    end

    int          n_vec = 0;
    int          n_bad = 0;
    logic [3:0]  exp_cnt;
    logic [3:0]  flg;
    assign flg = {rsp_zero, rsp_carry, rsp_sign, rsp_overflow};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [1:0] onehot(input int id);
        return (id == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [11:0] ref_alu(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x;
        x = a ^ b;
        return {x, (x == 8'h00), a[7], x[7], b[0]};
    endfunction

    function automatic int rr_pick(input logic [1:0] v, input int last);
        for (int k = 1; k <= 2; k++) begin
            int c;
            c = (last + k) % 2;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ops_done"}, 32'(ops_done), 32'd0);
        check({tag, "_alu_drive"}, 32'({alu_src_a, alu_src_b, alu_ctrl}), 32'd0);
        check({tag, "_rsp_data"}, 32'({rsp_result, flg}), 32'd0);
    endtask

    task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
        if (id == 1) begin
            req_a1 = a; req_b1 = b; req_op1 = op;
        end else begin
            req_a0 = a; req_b0 = b; req_op0 = op;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset   = 1'b0;
        exp_cnt = 4'd0;
    endtask

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        logic [7:0] res;
        logic [3:0] flags;   // {z, c, s, v}
    } vec_t;

    vec_t vt[6];

    task automatic do_txn(input vec_t v);
        set_req(v.id, v.a, v.b, v.op);
        req_valid = onehot(v.id);
        rsp_ready = 2'b00;
        #1;
        check("accept_ready", 32'(req_ready), 32'(onehot(v.id)));
        check("idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        check("exec_ctrl", 32'(alu_ctrl), 32'(v.op));
        check("exec_src", 32'({alu_src_a, alu_src_b}), 32'({v.a, v.b}));
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        check("exec_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("rsp_valid", 32'(rsp_valid), 32'(onehot(v.id)));
        check("rsp_result", 32'(rsp_result), 32'(v.res));
        check("rsp_flags", 32'(flg), 32'(v.flags));
        rsp_ready = onehot(v.id);
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        exp_cnt   = exp_cnt + 4'd1;
        check("done_count", 32'(ops_done), 32'(exp_cnt));
        check("done_rsp_valid", 32'(rsp_valid), 32'd0);
    endtask

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] op;
        int         age;
    } txn_t;

    initial begin
        txn_t       q[$];
        txn_t       t;
        int         m_last, w;
        logic [7:0] m_a, m_b;
        logic [1:0] m_op;
        logic [11:0] m_rsp;
        logic [3:0] m_cnt;
        logic       pend[2];
        logic [7:0] ra[2], rb[2];
        logic [1:0] rop[2];
        logic [1:0] exp_rv;

        vt[0] = '{0, 8'h0F, 8'h01, 2'b10, 8'h0E, 4'b0001};
        vt[1] = '{0, 8'hAA, 8'hAA, 2'b01, 8'h00, 4'b1100};
        vt[2] = '{1, 8'h80, 8'h7F, 2'b11, 8'hFF, 4'b0111};
        vt[3] = '{1, 8'h55, 8'h54, 2'b00, 8'h01, 4'b0000};
        vt[4] = '{1, 8'hF0, 8'h0F, 2'b11, 8'hFF, 4'b0111};
        vt[5] = '{0, 8'h00, 8'h00, 2'b00, 8'h00, 4'b1000};

        reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
        req_a0 = '0; req_b0 = '0; req_op0 = '0; req_a1 = '0; req_b1 = '0; req_op1 = '0;
        #1;
        check_all_zero("reset");
        do_reset();

        for (int i = 0; i < 6; i++) do_txn(vt[i]);

        // Contention: both valid continuously, grants must alternate starting with 0.
        do_reset();
        set_req(0, 8'h11, 8'h22, 2'b01);
        set_req(1, 8'h3C, 8'hC3, 2'b10);
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            int id;
            id = k % 2;
            #1;
            check("cont_grant", 32'(req_ready), 32'(onehot(id)));
            @(posedge clk); #1;
            check("cont_exec_ready", 32'(req_ready), 32'd0);
            check("cont_exec_ctrl", 32'(alu_ctrl), (id == 1) ? 32'd2 : 32'd1);
            @(posedge clk); #1;
            check("cont_rsp_route", 32'(rsp_valid), 32'(onehot(id)));
            check("cont_rsp_result", 32'(rsp_result), (id == 1) ? 32'hFF : 32'h33);
            @(posedge clk);
            exp_cnt = exp_cnt + 4'd1;
            #1;
            check("cont_count", 32'(ops_done), 32'(exp_cnt));
        end

        // Backpressure: requester 0 is next (last grant was 1); stall its response 5 cycles.
        rsp_ready = 2'b00;
        #1;
        check("bp_grant", 32'(req_ready), 32'(2'b01));
        @(posedge clk); #1;
        req_valid = 2'b10;
        @(posedge clk); #1;
        check("bp_rsp_valid", 32'(rsp_valid), 32'(2'b01));
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(rsp_valid), 32'(2'b01));
            check("bp_hold_data", 32'({rsp_result, flg}), 32'({8'h33, 4'b0000}));
            check("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 2'b01;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        exp_cnt   = exp_cnt + 4'd1;
        check("bp_count", 32'(ops_done), 32'(exp_cnt));
        check("bp_next_grant", 32'(req_ready), 32'(2'b10));
        @(posedge clk); #1;
        req_valid = 2'b00;
        check("bp_next_src", 32'(alu_src_a), 32'h3C);
        @(posedge clk); #1;
        check("bp_next_rsp", 32'({rsp_valid, rsp_result, flg}), 32'({2'b10, 8'hFF, 4'b0011}));
        rsp_ready = 2'b10;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        exp_cnt   = exp_cnt + 4'd1;
        check("bp_next_count", 32'(ops_done), 32'(exp_cnt));

        // Reset during EXEC and during RESP discards the operation.
        do_reset();
        set_req(0, 8'h0F, 8'h01, 2'b10);
        req_valid = 2'b01;
        @(posedge clk); #1;
        check("rst_exec_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_all_zero("rst_exec");
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 2'b11;
        #1;
        check("rst_exec_after", 32'(req_ready), 32'(2'b01));
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(posedge clk); #1;
        check("rst_resp_valid", 32'(rsp_valid), 32'(2'b01));
        reset = 1'b1;
        #1;
        check_all_zero("rst_resp");
        @(negedge clk);
        reset     = 1'b0;
        req_valid = 2'b11;
        #1;
        check("rst_resp_after", 32'(req_ready), 32'(2'b01));

        // Counter wrap after 16 completions.
        do_reset();
        for (int i = 0; i < 16; i++) do_txn(vt[i % 6]);
        check("wrap_zero", 32'(ops_done), 32'd0);

        // Random traffic against the transaction-level model.
        do_reset();
        q.delete();
        m_last = 1; m_a = '0; m_b = '0; m_op = '0; m_rsp = '0; m_cnt = '0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && $urandom_range(1, 0) == 1) begin
                    pend[i] = 1'b1;
                    ra[i]   = 8'($urandom);
                    rb[i]   = 8'($urandom);
                    rop[i]  = 2'($urandom);
                end
            end
            req_valid = {pend[1], pend[0]};
            set_req(0, ra[0], rb[0], rop[0]);
            set_req(1, ra[1], rb[1], rop[1]);
            rsp_ready = 2'($urandom_range(3, 0));
            #1;
            w = rr_pick(req_valid, m_last);
            exp_rv = (q.size() != 0 && q[0].age > 0) ? onehot(q[0].id) : 2'b00;
            check("rnd_req_ready", 32'(req_ready),
                  (q.size() == 0 && w >= 0) ? 32'(onehot(w)) : 32'd0);
            check("rnd_busy", 32'(busy), 32'(q.size() != 0));
            check("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            check("rnd_ops_done", 32'(ops_done), 32'(m_cnt));
            check("rnd_alu_drive", 32'({alu_src_a, alu_src_b, alu_ctrl}), 32'({m_a, m_b, m_op}));
            check("rnd_rsp_data", 32'({rsp_result, flg}), 32'(m_rsp));
            @(posedge clk);
            if (q.size() == 0) begin
                if (w >= 0) begin
                    t = '{w, ra[w], rb[w], rop[w], 0};
                    q.push_back(t);
                    m_last  = w;
                    m_a     = ra[w];
                    m_b     = rb[w];
                    m_op    = rop[w];
                    pend[w] = 1'b0;
                end
            end else if (q[0].age == 0) begin
                t     = q[0];
                t.age = 1;
                q[0]  = t;
                m_rsp = ref_alu(t.a, t.b);
            end else if (rsp_ready[q[0].id]) begin
                void'(q.pop_front());
                m_cnt = m_cnt + 4'd1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Sequencer and arbiter that shares one combinational `ALU_advanced` instance between two requesters, such as two cores' execute stages on a shared tile. It accepts operations over a valid/ready handshake and grants round-robin. It drives the ALU from registered operands, captures the result and the four flags, and returns them over a per-requester valid/ready response channel. It sits between the requesters and the ALU; the ALU itself is instantiated outside the block and wired to the `alu_*` ports.

## Interface
- `N`, default 32: datapath width; must match the attached `ALU_advanced #(N)`.
- `CNT_W`, default 16: width of the completed-operation counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  2  bit i: requester i presents an operation.
- `req_ready`  out  2  bit i: operation from requester i accepted this edge.
- `req_a0`, `req_b0`  in  N each  operands, requester 0.
- `req_op0`  in  2  ALU control code, requester 0.
- `req_a1`, `req_b1`  in  N each  operands, requester 1.
- `req_op1`  in  2  ALU control code, requester 1.
- `rsp_valid`  out  2  bit i: result for requester i is valid.
- `rsp_ready`  in  2  bit i: requester i consumes the result.
- `rsp_result`  out  N  captured ALU result.
- `rsp_zero`, `rsp_carry`, `rsp_sign`, `rsp_overflow`  out  1 each  captured flags.
- `alu_src_a`, `alu_src_b`  out  N each  ALU operands.
- `alu_ctrl`  out  2  ALU control code.
- `alu_out`  in  N  ALU result.
- `alu_zero`, `alu_carry`, `alu_sign`, `alu_overflow`  in  1 each  ALU flags.
- `busy`  out  1  high in any state other than IDLE.
- `ops_done`  out  CNT_W  count of completed responses; wraps modulo 2^CNT_W.

## Operation
- FSM states: IDLE, EXEC, RESP.
- Reset values:
  - State is IDLE.
  - `last_grant` = 1, so requester 0 wins the first contention.
  - All operand, op, result and flag registers are 0.
  - `req_ready` = 0, `rsp_valid` = 0, `busy` = 0, `ops_done` = 0.
  - `alu_src_a`, `alu_src_b` and `alu_ctrl` are 0.
- IDLE:
  - Winner: the only valid requester; if both are valid, the requester other than `last_grant`.
  - `req_ready[winner]` = 1 combinationally. The other bit is 0. Both bits are 0 when no request is valid.
  - On an edge with a handshake: latch the winner's a, b and op plus the winner id; set `last_grant` to the winner; go to EXEC.
- EXEC:
  - `alu_src_a`, `alu_src_b` and `alu_ctrl` are driven from the latched registers. They are registered outputs and stay stable for the whole cycle.
  - At the edge: capture `alu_out` and the four flags into the response registers; go to RESP.
- RESP:
  - `rsp_valid[id]` = 1; the other bit is 0. `rsp_result` and the flags hold steady.
  - On an edge with `rsp_ready[id]` = 1: increment `ops_done`; go to IDLE.
  - `rsp_ready` of the non-owner is ignored.
- `req_ready` is 0 in EXEC and RESP. Requests are held pending and never dropped.
- The ALU drive registers keep their last values outside EXEC; they are not cleared.
- The block does not decode or interpret the op code.

## Timing
- Request accepted at edge k; ALU is driven during cycle k+1; result captured at edge k+1.
- `rsp_valid` is high from just after edge k+1.
- Earliest response completion is edge k+2; earliest next acceptance is edge k+3.
- Peak throughput is one operation per 3 cycles.
- Back-to-back contention with both requesters always valid: grants alternate 0,1,0,1…
- A request that arrives while the block is busy waits; arbitration happens only in IDLE.
- Response stall: RESP holds indefinitely with all response outputs stable.
- Asynchronous reset in any state: all outputs immediately take their reset values. An in-flight operation and an unconsumed response are discarded, and `ops_done` is not incremented.
- `ops_done` wraps: at all-ones, a completion yields 0.

## Test plan
Bench uses N=8 and CNT_W=4, with an ALU stub: `alu_out` = a^b, `alu_zero` = (a^b==0), `alu_carry` = a[7], `alu_sign` = out[7], `alu_overflow` = b[0].

1. Single request: req0 a=8'h0F, b=8'h01, op=2'b10 → `req_ready` = 2'b01 at the accept edge; `alu_ctrl` = 2'b10 in EXEC; `rsp_valid` = 2'b01 one edge later; `rsp_result` = 8'h0E with flags z=0, c=0, s=0, v=1; `ops_done` = 1 after `rsp_ready`.
2. Contention: both requesters valid continuously for 4 transactions → grant order 0,1,0,1. Each response is routed only to its owner's `rsp_valid` bit.
3. Backpressure: `rsp_ready` = 0 for 5 cycles → RESP held; `rsp_result`, flags and `rsp_valid` stable; `req_ready` = 0 throughout; the second requester is accepted 1 edge after the release.
4. Zero flag: a=b=8'hAA → `rsp_result` = 0, `rsp_zero` = 1, `rsp_carry` = 1.
5. Reset in EXEC and in RESP → all outputs 0 immediately; `ops_done` is unchanged from 0 (no count for the discarded op); after release, requester 0 wins a simultaneous request.
6. 16 completions → `ops_done` wraps from 4'hF to 4'h0.
